seg_scan_mux: RTL



---
 rtl/clock_pkg.sv | 50 +++++
 rtl/seg7_hex_decode.sv | 36 +++
 rtl/seg_scan_mux.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the clock display blocks.
// Provides the digit width, active-high 7-segment glyphs for 0..F
// ({g,f,e,d,c,b,a} bit order), the segment/dp drive payload and a
// helper that applies output polarity to that payload.
package clock_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned SEG_W   = 7;

  // Active-high glyphs, bit 0 = segment a
  localparam logic [SEG_W-1:0] SEG_OFF = 7'h00;
  localparam logic [SEG_W-1:0] SEG_0   = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1   = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2   = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3   = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4   = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5   = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6   = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7   = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8   = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9   = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_A   = 7'h77;
  localparam logic [SEG_W-1:0] SEG_B   = 7'h7C;
  localparam logic [SEG_W-1:0] SEG_C   = 7'h39;
  localparam logic [SEG_W-1:0] SEG_D   = 7'h5E;
  localparam logic [SEG_W-1:0] SEG_E   = 7'h79;
  localparam logic [SEG_W-1:0] SEG_F   = 7'h71;

  // Blink half-period phase; VISIBLE is the reset phase
  typedef enum logic {
    BLINK_VISIBLE = 1'b0,
    BLINK_HIDDEN  = 1'b1
  } blink_phase_e;

  // Cathode-side drive for one digit slot
  typedef struct packed {
    logic [SEG_W-1:0] seg;
    logic             dp;
  } seg_drive_t;

  // Convert an active-high drive payload to the board polarity
  function automatic seg_drive_t drive_polarity(input seg_drive_t drv,
                                                input logic       active_low);
    seg_drive_t res;
    res.seg = active_low ? ~drv.seg : drv.seg;
    res.dp  = active_low ? ~drv.dp  : drv.dp;
    return res;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-high 7-segment decoder.
// Ports:
//   nibble_i : 4-bit digit value 0..F
//   seg_c    : active-high segments {g,f,e,d,c,b,a}
module seg7_hex_decode
  import clock_pkg::*;
(
  input  logic [DIGIT_W-1:0] nibble_i,
  output logic [SEG_W-1:0]   seg_c
);

  // Glyph lookup
  always_comb begin
    seg_c = SEG_OFF;
    case (nibble_i)
      4'h0: seg_c = SEG_0;
      4'h1: seg_c = SEG_1;
      4'h2: seg_c = SEG_2;
      4'h3: seg_c = SEG_3;
      4'h4: seg_c = SEG_4;
      4'h5: seg_c = SEG_5;
      4'h6: seg_c = SEG_6;
      4'h7: seg_c = SEG_7;
      4'h8: seg_c = SEG_8;
      4'h9: seg_c = SEG_9;
      4'hA: seg_c = SEG_A;
      4'hB: seg_c = SEG_B;
      4'hC: seg_c = SEG_C;
      4'hD: seg_c = SEG_D;
      4'hE: seg_c = SEG_E;
      4'hF: seg_c = SEG_F;
      default: seg_c = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed 7-segment scanner for common-anode displays.
// One digit slot lasts SCAN_DIV clocks; the first DEAD_CYCLES of each slot
// keep every anode off so the previous digit cannot ghost into the next.
// Supports per-digit blanking, blinking, decimal points, optional
// leading-zero suppression and selectable segment/anode polarity.
// Ports:
//   clk        : system clock
//   nCLR       : asynchronous active-low reset
//   en         : scan enable; 0 holds all counters and darkens the display
//   value      : packed nibbles, nibble i = digit i (digit 0 rightmost)
//   blank_mask : 1 = digit forced dark
//   blink_mask : 1 = digit dark during the hidden blink phase
//   dp_mask    : 1 = decimal point of digit lit
//   digits     : registered segments {g,f,e,d,c,b,a}
//   dp         : registered decimal point
//   AN         : registered anode enables, one-hot when a digit is lit
//   frame_tick : registered one-clock pulse when the scan wraps to digit 0
module seg_scan_mux
  import clock_pkg::*;
#(
  parameter int unsigned N_DIGITS       = 6,
  parameter int unsigned SCAN_DIV       = 138889,
  parameter int unsigned DEAD_CYCLES    = 2,
  parameter int unsigned BLINK_FRAMES   = 60,
  parameter int unsigned LZ_SUPPRESS    = 0,
  parameter int unsigned SEG_ACTIVE_LOW = 1,
  parameter int unsigned AN_ACTIVE_LOW  = 1
) (
  input  logic                        clk,
  input  logic                        nCLR,
  input  logic                        en,
  input  logic [DIGIT_W*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]         blank_mask,
  input  logic [N_DIGITS-1:0]         blink_mask,
  input  logic [N_DIGITS-1:0]         dp_mask,
  output logic [SEG_W-1:0]            digits,
  output logic                        dp,
  output logic [N_DIGITS-1:0]         AN,
  output logic                        frame_tick
);

  localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = $clog2(N_DIGITS);
  localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic SEG_AL = (SEG_ACTIVE_LOW != 0);
  localparam logic AN_AL  = (AN_ACTIVE_LOW != 0);
  localparam logic LZ_EN  = (LZ_SUPPRESS != 0);

  // Inactive levels after polarity, used for reset and dark slots
  localparam logic [N_DIGITS-1:0] AN_OFF    = {N_DIGITS{AN_AL}};
  localparam seg_drive_t          DRIVE_OFF = seg_drive_t'({{SEG_W{SEG_AL}}, SEG_AL});

  // Scan state
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [FRM_W-1:0]    frm_q, frm_d;
  blink_phase_e        phase_q, phase_d;

  // Registered outputs
  logic [N_DIGITS-1:0] an_q, an_d;
  seg_drive_t          drv_q, drv_d;
  logic                tick_q, tick_d;

  // Combinational helpers
  logic                slot_end;
  logic                frame_wrap;
  logic [DIGIT_W-1:0]  cur_nib;
  logic                cur_blank;
  logic                cur_blink;
  logic                cur_dp;
  logic                cur_lz;
  logic [N_DIGITS-1:0] slot_onehot;
  logic [N_DIGITS-1:0] lz_dark;
  logic [SEG_W-1:0]    dec_seg;
  logic                dead;
  logic                dark;
  logic [N_DIGITS-1:0] an_raw;
  seg_drive_t          drv_raw;

  // Prescaler, digit index, frame counter and blink phase next state.
  // Nothing advances while en=0, so slot_end can only fire when enabled.
  always_comb begin
    pre_d      = pre_q;
    idx_d      = idx_q;
    frm_d      = frm_q;
    phase_d    = phase_q;
    slot_end   = en && (pre_q == PRE_W'(SCAN_DIV - 1));
    frame_wrap = slot_end && (idx_q == IDX_W'(N_DIGITS - 1));
    tick_d     = frame_wrap;

    if (en) begin
      if (slot_end) begin
        pre_d = '0;
        idx_d = frame_wrap ? '0 : idx_q + IDX_W'(1);
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end

    if (frame_wrap) begin
      if (frm_q == FRM_W'(BLINK_FRAMES - 1)) begin
        frm_d   = '0;
        phase_d = (phase_q == BLINK_VISIBLE) ? BLINK_HIDDEN : BLINK_VISIBLE;
      end else begin
        frm_d = frm_q + FRM_W'(1);
      end
    end
  end

  // Leading-zero map: walk from the MSB down while every nibble seen is zero.
  // Digit 0 is always shown so an all-zero value still displays "0".
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    lz_dark    = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (value[i*DIGIT_W +: DIGIT_W] == '0);
      lz_dark[i] = LZ_EN && (i > 0) && upper_zero;
    end
  end

  // Select the current digit's nibble and attributes
  always_comb begin
    cur_nib     = '0;
    cur_blank   = 1'b0;
    cur_blink   = 1'b0;
    cur_dp      = 1'b0;
    cur_lz      = 1'b0;
    slot_onehot = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib        = value[i*DIGIT_W +: DIGIT_W];
        cur_blank      = blank_mask[i];
        cur_blink      = blink_mask[i];
        cur_dp         = dp_mask[i];
        cur_lz         = lz_dark[i];
        slot_onehot[i] = 1'b1;
      end
    end
  end

  seg7_hex_decode u_dec (
    .nibble_i (cur_nib),
    .seg_c    (dec_seg)
  );

  // Slot drive: a dark digit keeps its time slot but drives nothing.
  // Polarity is applied as the very last step.
  always_comb begin
    an_raw      = '0;
    drv_raw.seg = SEG_OFF;
    drv_raw.dp  = 1'b0;
    dead        = (pre_q < PRE_W'(DEAD_CYCLES));
    dark        = !en || dead || cur_blank || cur_lz ||
                  (cur_blink && (phase_q == BLINK_HIDDEN));
    if (!dark) begin
      an_raw      = slot_onehot;
      drv_raw.seg = dec_seg;
      drv_raw.dp  = cur_dp;
    end
    an_d  = AN_AL ? ~an_raw : an_raw;
    drv_d = drive_polarity(drv_raw, SEG_AL);
  end

  // State and output registers
  always_ff @(posedge clk or negedge nCLR) begin
    if (!nCLR) begin
      pre_q   <= '0;
      idx_q   <= '0;
      frm_q   <= '0;
      phase_q <= BLINK_VISIBLE;
      an_q    <= AN_OFF;
      drv_q   <= DRIVE_OFF;
      tick_q  <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      frm_q   <= frm_d;
      phase_q <= phase_d;
      an_q    <= an_d;
      drv_q   <= drv_d;
      tick_q  <= tick_d;
    end
  end

  assign digits     = drv_q.seg;
  assign dp         = drv_q.dp;
  assign AN         = an_q;
  assign frame_tick = tick_q;

endmodule
